// File: rtl/mul_seq16_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq16_if
//  Purpose  : Request/result bundle for the sequential multiplier.
//  Revision : 1.0
// ============================================================================
interface mul_seq16_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, product, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, overflow
    );
endinterface
`default_nettype wire

// File: rtl/mul_seq16.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq16
//  Purpose  : Unsigned shift-add multiplier, one multiplier bit per clock,
//             registered product/overflow held until the next accepted start.
//  Revision : 1.0
// ============================================================================
module mul_seq16 #(
    parameter int WIDTH = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mul_seq16_if.slave bus
);
    localparam int               c_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   w_mcand_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     w_mplier_nxt;
    logic [WIDTH-1:0]     r_product;
    logic [WIDTH-1:0]     w_product_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_overflow;
    logic                 w_overflow_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_product  <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mcand    <= w_mcand_nxt;
            r_acc      <= w_acc_nxt;
            r_mplier   <= w_mplier_nxt;
            r_cnt      <= w_cnt_nxt;
            r_product  <= w_product_nxt;
            r_overflow <= w_overflow_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // The accumulator is twice the operand width, so this sum never wraps.
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = r_acc + w_addend;

    always_comb begin
        w_state_nxt    = r_state;
        w_mcand_nxt    = r_mcand;
        w_acc_nxt      = r_acc;
        w_mplier_nxt   = r_mplier;
        w_cnt_nxt      = r_cnt;
        w_product_nxt  = r_product;
        w_overflow_nxt = r_overflow;
        w_done_nxt     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_mcand_nxt  = {{WIDTH{1'b0}}, bus.a};
                    w_mplier_nxt = bus.b;
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                w_acc_nxt    = w_sum;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + c_CNT_ONE;
                if (r_cnt == c_CNT_LAST) begin
                    // Publish from the sum so the last partial product is included.
                    w_product_nxt  = w_sum[WIDTH-1:0];
                    w_overflow_nxt = |w_sum[2*WIDTH-1:WIDTH];
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.product  = r_product;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire
